// File: rtl/diffeq_pkg.sv
// Shared types and helpers for the diffeq solver datapath: FSM encoding,
// default multiplier geometry and the round-robin pick used by mul_share_arbiter.
package diffeq_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_MUL_LAT = 2;
  localparam int unsigned RR_MAX      = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from ptr, wrapping to 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [2:0]        ptr,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = (32'(ptr) + i) % n;
      if (i < n && !r.found && req[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_mul_pipe.sv
// mul_pipe: LAT-stage registered signed multiplier; stage 0 captures a*b when en is high.
module mul_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] ax, bx, prod;
  logic signed [2*WIDTH-1:0] st [LAT];

  always_comb begin
    ax   = {{WIDTH{a[WIDTH-1]}}, a};
    bx   = {{WIDTH{b[WIDTH-1]}}, b};
    prod = ax * bx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) st[i] <= '0;
    end else begin
      if (en) st[0] <= prod;
      for (int unsigned i = 1; i < LAT; i++) st[i] <= st[i-1];
    end
  end

  assign p = st[LAT-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NREQ requesters.
// Optional perf counters (grant_cnt, busy_cyc) when MUL_SHARE_ARBITER_PERF_EN is defined.
module mul_share_arbiter
  import diffeq_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [2*WIDTH-1:0]      result,
`ifdef MUL_SHARE_ARBITER_PERF_EN
  output logic [NREQ*16-1:0]      grant_cnt,
  output logic [31:0]             busy_cyc,
`endif
  output logic                    busy
);

  localparam int unsigned CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  state_t                    state_r, state_n;
  logic [CW-1:0]             cnt_r, cnt_n;
  logic [2:0]                ptr_r, ptr_n, win_r, win_n;
  logic [NREQ-1:0]           gnt_n, done_n;
  logic [2*WIDTH-1:0]        result_n;
  logic                      busy_n, cap;
  rr_pick_t                  pick;
  logic signed [WIDTH-1:0]   a_sel, b_sel;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    pick     = rr_pick(RR_MAX'(req), ptr_r, NREQ);
    a_sel    = op_a[32'(pick.idx)*WIDTH +: WIDTH];
    b_sel    = op_b[32'(pick.idx)*WIDTH +: WIDTH];
    state_n  = state_r;
    cnt_n    = cnt_r;
    ptr_n    = ptr_r;
    win_n    = win_r;
    gnt_n    = '0;
    done_n   = '0;
    busy_n   = busy_r_q();
    result_n = result;
    cap      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pick.found) begin
          cap     = 1'b1;
          win_n   = pick.idx;
          gnt_n   = NREQ'(1) << pick.idx;
          busy_n  = 1'b1;
          cnt_n   = CW'(MUL_LAT);
          state_n = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_n = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          result_n = prod;
          done_n   = NREQ'(1) << win_r;
          busy_n   = 1'b0;
          ptr_n    = (win_r == 3'(NREQ - 1)) ? '0 : win_r + 3'd1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  function automatic logic busy_r_q();
    return busy;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      ptr_r   <= '0;
      win_r   <= '0;
      gnt     <= '0;
      done    <= '0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ptr_r   <= ptr_n;
      win_r   <= win_n;
      gnt     <= gnt_n;
      done    <= done_n;
      result  <= result_n;
      busy    <= busy_n;
    end
  end

  mul_pipe #(
    .WIDTH (WIDTH),
    .LAT   (MUL_LAT)
  ) u_mul_pipe (
    .clk   (clk),
    .reset (reset),
    .en    (cap),
    .a     (a_sel),
    .b     (b_sel),
    .p     (prod)
  );

`ifdef MUL_SHARE_ARBITER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
      busy_cyc  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (gnt[i] && grant_cnt[i*16 +: 16] != '1)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      if (busy && busy_cyc != '1) busy_cyc <= busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (NREQ=4, WIDTH=16, MUL_LAT=2).
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a, op_b;
  logic [NREQ-1:0]   gnt, done;
  logic [2*W-1:0]    result;
  logic              busy;
`ifdef MUL_SHARE_ARBITER_PERF_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [31:0]        busy_cyc;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (W),
    .MUL_LAT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
`ifdef MUL_SHARE_ARBITER_PERF_EN
    .grant_cnt (grant_cnt),
    .busy_cyc  (busy_cyc),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    op_a[i*W +: W] = 16'(a);
    op_b[i*W +: W] = 16'(b);
  endtask

  task automatic wait_gnt(input string tag, output int at);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = (gnt != '0);
    end
    if (!seen) chk({tag, "_timeout"}, 64'(seen), 64'd1);
    at = cyc;
  endtask

  task automatic wait_done(input string tag, output int at);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = (done != '0);
    end
    if (!seen) chk({tag, "_timeout"}, 64'(seen), 64'd1);
    at = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] rr_exp [4] = '{32'h00000038, 32'hFFFFD8F0, 32'h40000000, 32'hC0008000};

  initial begin
    int tg, tprev, td;
    logic [NREQ-1:0] acc;
    reset = 1'b1;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    step();
    step();
    chk("reset_outs", 64'({gnt, done, busy, result}), 64'd0);
    reset = 1'b0;

    // Single request: 3 * -5
    set_op(1, 3, -5);
    req = 4'b0010;
    step();
    chk("t1_gnt", 64'(gnt), 64'h2);
    chk("t1_busy0", 64'(busy), 64'd1);
    req = '0;
    step();
    chk("t1_mid", 64'({gnt, done, busy}), 64'({4'b0, 4'b0, 1'b1}));
    step();
    chk("t1_done", 64'({done, busy}), 64'({4'b0010, 1'b0}));
    chk("t1_result", 64'(result), 64'hFFFFFFF1);
    step();
    chk("t1_hold", 64'({done, result}), 64'({4'b0, 32'hFFFFFFF1}));

    // Continuous load from all four requesters after reset
    do_reset();
    set_op(0, 7, 8);
    set_op(1, 100, -100);
    set_op(2, -32768, -32768);
    set_op(3, 32767, -32768);
    req   = 4'b1111;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt", tg);
      chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 64'(tg - tprev), 64'd3);
      tprev = tg;
      wait_done("rr_done", td);
      chk($sformatf("rr_lat%0d", k), 64'(td - tg), 64'd2);
      chk($sformatf("rr_done%0d", k), 64'(done), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr_res%0d", k), 64'(result), 64'(rr_exp[k % 4]));
    end
    req = '0;

    // Reset one cycle after gnt[2]; pointer sits at 1 beforehand
    set_op(2, 5, 6);
    req = 4'b0100;
    wait_gnt("mr_gnt", tg);
    chk("mr_gnt", 64'(gnt), 64'h4);
    req = '0;
    step();
    reset = 1'b1;
    #1;
    chk("mr_async", 64'({gnt, done, busy, result}), 64'd0);
    step();
    reset = 1'b0;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      acc |= done;
    end
    chk("mr_no_done", 64'(acc), 64'd0);
    req = 4'b1001;
    wait_gnt("mr_regnt", tg);
    chk("mr_ptr0", 64'(gnt), 64'h1);
    req = '0;
    wait_done("mr_done", td);
    chk("mr_done", 64'({done, result}), 64'({4'b0001, 32'h00000038}));

    // Requests arriving while busy wait for the next IDLE arbitration
    req = 4'b0100;
    wait_gnt("bz_gnt", tg);
    chk("bz_gnt2", 64'(gnt), 64'h4);
    req = 4'b1001;
    step();
    chk("bz_hold1", 64'({gnt, busy}), 64'({4'b0, 1'b1}));
    step();
    chk("bz_done", 64'({gnt, done, result}), 64'({4'b0, 4'b0100, 32'h0000001E}));
    step();
    chk("bz_gnt3", 64'(gnt), 64'h8);
    req = '0;
    wait_done("bz_done3", td);
    chk("bz_res3", 64'({done, result}), 64'({4'b1000, 32'hC0008000}));

`ifdef MUL_SHARE_ARBITER_PERF_EN
    do_reset();
    set_op(1, 3, -5);
    for (int k = 0; k < 5; k++) begin
      req = 4'b0010;
      wait_gnt("pf_gnt", tg);
      req = '0;
      wait_done("pf_done", td);
    end
    step();
    chk("pf_gcnt1", 64'(grant_cnt[31:16]), 64'd5);
    chk("pf_busy", 64'(busy_cyc), 64'd10);
    force dut.grant_cnt = '1;
    force dut.busy_cyc  = '1;
    step();
    release dut.grant_cnt;
    release dut.busy_cyc;
    req = 4'b0010;
    wait_gnt("pf_sgnt", tg);
    req = '0;
    wait_done("pf_sdone", td);
    step();
    chk("pf_gsat", 64'(grant_cnt[31:16]), 64'hFFFF);
    chk("pf_bsat", 64'(busy_cyc), 64'hFFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed multi-cycle multiplier among NREQ datapath requesters of the diffeq solver (x*dx, u*dx, 3*x, 3*y products).
- Round-robin arbitration; at most one operation in flight.
- Uses a req/gnt/done handshake so the compute-stage controller can sequence COMPUTE_1..4 without a dedicated multiplier per stage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, signed operand width; product width is 2*WIDTH.
- MUL_LAT, 2, multiplier pipeline depth in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; requester i holds req[i], op_a and op_b stable until it sees gnt[i].
- op_a  in  NREQ*WIDTH  signed operand A; slice i is [i*WIDTH +: WIDTH].
- op_b  in  NREQ*WIDTH  signed operand B; same slicing.
- gnt  out  NREQ  one-hot, one-cycle pulse: the operands of requester i have been captured.
- done  out  NREQ  one-hot, one-cycle pulse: result is valid for requester i.
- result  out  2*WIDTH  signed product; held until the next done.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset (asynchronous, immediate) clears all state and outputs:
  - gnt=0, done=0, result=0, busy=0.
  - Round-robin pointer=0, state=S_IDLE.
  - Any in-flight operation is discarded; no done pulse is issued for it.
- FSM states: S_IDLE, S_BUSY.
- S_IDLE:
  - If any req bit is high at a rising edge, pick the winner: the first set bit searching upward from the pointer, wrapping at NREQ-1 -> 0.
  - At that edge: latch the winner index and its operands, gnt[winner]<=1, busy<=1, cnt<=MUL_LAT, state<=S_BUSY.
  - With no req, stay in S_IDLE with outputs low.
- S_BUSY:
  - gnt drops after its single cycle.
  - cnt decrements each edge while the multiplier pipeline advances.
  - At the edge where cnt==1: result<=product, done[winner]<=1, busy<=0, pointer<=winner+1 (wrapping), state<=S_IDLE.
- Latency and throughput:
  - Grant edge E -> done high in the cycle after edge E+MUL_LAT.
  - The next grant can occur no earlier than edge E+MUL_LAT+1.
  - One operation per MUL_LAT+1 cycles under continuous load.
- req is ignored in S_BUSY; requests stay pending, with no queueing beyond the level of req.
- A requester that keeps req high after its gnt is treated as issuing a new operation. Fairness still holds because the pointer has moved past it.
- A requester may assert req in the same cycle its done is high; it is eligible at the next IDLE arbitration.
- Arithmetic: full-precision signed product, no truncation or saturation. Width is exact: 2*WIDTH.
- done and gnt are never high for two requesters at once, and gnt and done never target the same operation in one cycle.

Optional Feature:
- Macro: MUL_SHARE_ARBITER_PERF_EN.
- With the macro defined:
  - Adds output ports grant_cnt (NREQ*16), per-requester saturating grant counters, and busy_cyc (32), a saturating count of cycles with busy=1.
  - Both counters clear on reset.
  - grant_cnt slice i increments on each gnt[i]; both counters stick at all-ones.
- Without the macro: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package diffeq_pkg holds:
  - FSM state localparams (S_IDLE=1'b0, S_BUSY=1'b1).
  - Default WIDTH and MUL_LAT constants.
  - A round-robin-pick function: (req vector, pointer) -> index and found flag.
- One sub-module, mul_pipe: a MUL_LAT-stage registered signed multiplier (inputs a, b, an enable at capture; output p).
- The arbiter instantiates mul_pipe once.

Test Plan:
- Single request: req=4'b0010, op_a[1]=3, op_b[1]=-5, MUL_LAT=2 -> gnt=4'b0010 for 1 cycle; done=4'b0010 two cycles later; result=32'hFFFFFFF1; busy high for 2 cycles.
- All four req held high continuously after reset -> grants in order 0,1,2,3,0, each spaced MUL_LAT+1=3 cycles; each done matches its own operands (e.g. 7*8=56, 100*-100=-10000).
- Extremes: op_a=-32768, op_b=-32768 -> result=32'h40000000; op_a=32767, op_b=-32768 -> result=32'hC0008000.
- Reset mid-operation: assert reset one cycle after gnt[2] -> gnt, done, busy and result all 0 immediately; no done pulse for requester 2; next req=4'b0001 is granted to requester 0 (pointer reset).
- Request during BUSY: req[3] rises while busy=1 -> no gnt until the cycle after done; then gnt[3], even if req[0] is also high and the pointer is 3.
- With MUL_SHARE_ARBITER_PERF_EN: 5 operations by requester 1 -> grant_cnt slice 1 = 5, busy_cyc = 10; counters stick at all-ones under forced saturation.
